// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants and helpers for the inter-stage pipeline buffer.
// Sizes match the widest legal buffer (4 entries, 3-bit occupancy).
package pipe_stage_buf_pkg;

    localparam int PIPE_MAX_DEPTH = 4;
    localparam int PIPE_CNT_W     = 3;
    localparam int PIPE_PTR_W     = 2;

    // Advance a circular pointer, wrapping after entry depth-1.
    function automatic logic [PIPE_PTR_W-1:0] ptr_next(
        input logic [PIPE_PTR_W-1:0] p,
        input int                    depth
    );
        if (p == PIPE_PTR_W'(depth - 1)) begin
            return '0;
        end
        return p + PIPE_PTR_W'(1);
    endfunction

endpackage

// File: rtl/pipe_stage_buf_ptr_ctr.sv
// Wrap-at-DEPTH pointer with increment and synchronous clear.
// Used for both the read and the write side of the buffer.
module pipe_ptr_ctr
    import pipe_stage_buf_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [PIPE_PTR_W-1:0] ptr_o
);

    logic [PIPE_PTR_W-1:0] ptr_q;
    logic [PIPE_PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_next(ptr_q, DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic 1..4 entry inter-stage buffer using the valid/allow/ready_go handshake.
// DEPTH=1 with ALLOW_PASSTHRU=1 is cycle-identical to the classic stage register.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W         = 96,
    parameter int DEPTH          = 1,
    parameter int ALLOW_PASSTHRU = 1,
    parameter int ZERO_ON_EMPTY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  validin,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_allow,
    input  logic                  pipe_ready_go,
    input  logic                  out_allow,
    output logic                  validout,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $fatal(1, "pipe_stage_buf: DEPTH must be in 1..4");
    end
    // A non-passthrough single entry can only alternate fill/drain.
    if (ALLOW_PASSTHRU == 0 && DEPTH == 1) begin : g_bad_passthru
        $fatal(1, "pipe_stage_buf: ALLOW_PASSTHRU=0 requires DEPTH>=2");
    end

    localparam logic [PIPE_CNT_W-1:0] DEPTH_C = PIPE_CNT_W'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;
    logic [PIPE_CNT_W-1:0]        count_q;
    logic [PIPE_CNT_W-1:0]        count_d;
    logic [PIPE_PTR_W-1:0]        wr_ptr;
    logic [PIPE_PTR_W-1:0]        rd_ptr;
    logic [DATA_W-1:0]            head;
    logic                         empty;
    logic                         full;
    logic                         push;
    logic                         pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    always_comb begin
        in_allow = clear || !full;
        if (ALLOW_PASSTHRU != 0) begin
            in_allow = in_allow || (pipe_ready_go && out_allow && !empty);
        end
    end

    assign validout = !empty && pipe_ready_go && !clear;
    assign push     = validin && in_allow && !clear;
    assign pop      = validout && out_allow;

    pipe_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clear),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    pipe_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clear),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    // Push wins over pop-zeroing: when wr_ptr==rd_ptr (full) the popped slot becomes the tail.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (clear) begin
                mem_d[i] = '0;
            end else if (push && wr_ptr == PIPE_PTR_W'(i)) begin
                mem_d[i] = in_data;
            end else if (pop && rd_ptr == PIPE_PTR_W'(i) && ZERO_ON_EMPTY != 0) begin
                mem_d[i] = '0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + PIPE_CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - PIPE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PIPE_PTR_W'(i)) begin
                head = mem_q[i];
            end
        end
    end

    assign out_data = (ZERO_ON_EMPTY != 0 && empty) ? '0 : head;
    assign count    = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed vector bench: five buffer configurations share one stimulus bus,
// each table row names the instance whose outputs it checks.
module tb_pipe_stage_buf;

    localparam int DW = 16;
    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst, clear, validin, prg, oa;
    logic [DW-1:0] in_data;

    logic [NI-1:0]         ia;
    logic [NI-1:0]         vo;
    logic [NI-1:0][DW-1:0] od;
    logic [NI-1:0][2:0]    cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: D1/PT1  1: D2/PT0  2: D4/PT1  3: D3/PT1  4: D2/PT1
    pipe_stage_buf #(.DATA_W(DW), .DEPTH(1), .ALLOW_PASSTHRU(1)) u_d1 (
        .clk(clk), .rst(rst), .clear(clear), .validin(validin), .in_data(in_data),
        .in_allow(ia[0]), .pipe_ready_go(prg), .out_allow(oa),
        .validout(vo[0]), .out_data(od[0]), .count(cnt[0]));
    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .ALLOW_PASSTHRU(0)) u_d2n (
        .clk(clk), .rst(rst), .clear(clear), .validin(validin), .in_data(in_data),
        .in_allow(ia[1]), .pipe_ready_go(prg), .out_allow(oa),
        .validout(vo[1]), .out_data(od[1]), .count(cnt[1]));
    pipe_stage_buf #(.DATA_W(DW), .DEPTH(4), .ALLOW_PASSTHRU(1)) u_d4 (
        .clk(clk), .rst(rst), .clear(clear), .validin(validin), .in_data(in_data),
        .in_allow(ia[2]), .pipe_ready_go(prg), .out_allow(oa),
        .validout(vo[2]), .out_data(od[2]), .count(cnt[2]));
    pipe_stage_buf #(.DATA_W(DW), .DEPTH(3), .ALLOW_PASSTHRU(1)) u_d3 (
        .clk(clk), .rst(rst), .clear(clear), .validin(validin), .in_data(in_data),
        .in_allow(ia[3]), .pipe_ready_go(prg), .out_allow(oa),
        .validout(vo[3]), .out_data(od[3]), .count(cnt[3]));
    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .ALLOW_PASSTHRU(1)) u_d2p (
        .clk(clk), .rst(rst), .clear(clear), .validin(validin), .in_data(in_data),
        .in_allow(ia[4]), .pipe_ready_go(prg), .out_allow(oa),
        .validout(vo[4]), .out_data(od[4]), .count(cnt[4]));

    typedef struct {
        bit          chk;
        int          inst;
        bit          r, c, vi;
        logic [15:0] d;
        bit          g, a;
        bit          e_ia, e_vo;
        logic [15:0] e_od;
        logic [2:0]  e_cnt;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit chk, input int inst, input bit r, input bit c,
                       input bit vi, input logic [15:0] d, input bit g, input bit a,
                       input bit e_ia, input bit e_vo, input logic [15:0] e_od,
                       input logic [2:0] e_cnt, input string tag);
        vec_t v;
        v.chk = chk; v.inst = inst; v.r = r; v.c = c; v.vi = vi; v.d = d;
        v.g = g; v.a = a; v.e_ia = e_ia; v.e_vo = e_vo; v.e_od = e_od;
        v.e_cnt = e_cnt; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit vi, input logic [15:0] d,
                         input bit g, input bit a);
        rst = r; clear = c; validin = vi; in_data = d; prg = g; oa = a;
    endtask

    task automatic rst_row(input int inst, input string tag);
        add(0, inst, 1, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 3'd0, tag);
    endtask

    initial begin
        drive(1, 0, 0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // T1: DEPTH=1 legacy stage register behaviour
        add(1, 0, 0, 0, 0, 16'h00, 1, 1, 1, 0, 16'h00, 3'd0, "t1_reset_state");
        add(1, 0, 0, 0, 1, 16'h0A, 1, 1, 1, 0, 16'h00, 3'd0, "t1_push_a");
        add(1, 0, 0, 0, 1, 16'h0B, 1, 1, 1, 1, 16'h0A, 3'd1, "t1_out_a");
        add(1, 0, 0, 0, 1, 16'h0C, 1, 1, 1, 1, 16'h0B, 3'd1, "t1_out_b");
        add(1, 0, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h0C, 3'd1, "t1_out_c");
        add(1, 0, 0, 0, 0, 16'h00, 1, 1, 1, 0, 16'h00, 3'd0, "t1_empty");
        add(1, 0, 0, 0, 1, 16'h0D, 1, 0, 1, 0, 16'h00, 3'd0, "t1_push_d");
        add(1, 0, 0, 0, 1, 16'h0E, 1, 0, 0, 1, 16'h0D, 3'd1, "t1_full_stall");
        add(1, 0, 0, 0, 1, 16'h0E, 1, 1, 1, 1, 16'h0D, 3'd1, "t1_swap");
        add(1, 0, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h0E, 3'd1, "t1_out_e");
        add(1, 0, 0, 0, 0, 16'h00, 1, 1, 1, 0, 16'h00, 3'd0, "t1_drained");

        // T2: DEPTH=2 registered allow under backpressure
        rst_row(1, "t2_rst");
        add(1, 1, 0, 0, 1, 16'h01, 1, 0, 1, 0, 16'h00, 3'd0, "t2_push1");
        add(1, 1, 0, 0, 1, 16'h02, 1, 0, 1, 1, 16'h01, 3'd1, "t2_push2");
        add(1, 1, 0, 0, 1, 16'h03, 1, 0, 0, 1, 16'h01, 3'd2, "t2_full");
        add(1, 1, 0, 0, 1, 16'h03, 1, 0, 0, 1, 16'h01, 3'd2, "t2_hold");
        add(1, 1, 0, 0, 1, 16'h03, 1, 1, 0, 1, 16'h01, 3'd2, "t2_pop1");
        add(1, 1, 0, 0, 1, 16'h03, 1, 1, 1, 1, 16'h02, 3'd1, "t2_pop2_push3");
        add(1, 1, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h03, 3'd1, "t2_pop3");
        add(1, 1, 0, 0, 0, 16'h00, 1, 1, 1, 0, 16'h00, 3'd0, "t2_empty");

        // T3: DEPTH=4 ready_go stall then drain
        rst_row(2, "t3_rst");
        add(1, 2, 0, 0, 1, 16'h10, 0, 1, 1, 0, 16'h00, 3'd0, "t3_fill0");
        add(1, 2, 0, 0, 1, 16'h11, 0, 1, 1, 0, 16'h10, 3'd1, "t3_fill1");
        add(1, 2, 0, 0, 1, 16'h12, 0, 1, 1, 0, 16'h10, 3'd2, "t3_fill2");
        add(1, 2, 0, 0, 1, 16'h13, 0, 1, 1, 0, 16'h10, 3'd3, "t3_fill3");
        add(1, 2, 0, 0, 0, 16'h00, 0, 1, 0, 0, 16'h10, 3'd4, "t3_full_stalled");
        add(1, 2, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h10, 3'd4, "t3_out10");
        add(1, 2, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h11, 3'd3, "t3_out11");
        add(1, 2, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h12, 3'd2, "t3_out12");
        add(1, 2, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h13, 3'd1, "t3_out13");
        add(1, 2, 0, 0, 0, 16'h00, 1, 1, 1, 0, 16'h00, 3'd0, "t3_empty");

        // T4: DEPTH=3 flush while full with an incoming beat
        rst_row(3, "t4_rst");
        add(1, 3, 0, 0, 1, 16'h21, 1, 0, 1, 0, 16'h00, 3'd0, "t4_push21");
        add(1, 3, 0, 0, 1, 16'h22, 1, 0, 1, 1, 16'h21, 3'd1, "t4_push22");
        add(1, 3, 0, 0, 1, 16'h23, 1, 0, 1, 1, 16'h21, 3'd2, "t4_push23");
        add(1, 3, 0, 1, 1, 16'h55, 1, 1, 1, 0, 16'h21, 3'd3, "t4_clear_cycle");
        add(1, 3, 0, 0, 1, 16'h66, 1, 1, 1, 0, 16'h00, 3'd0, "t4_after_clear");
        add(1, 3, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h66, 3'd1, "t4_fresh_beat");
        add(1, 3, 0, 0, 0, 16'h00, 1, 1, 1, 0, 16'h00, 3'd0, "t4_empty");

        // T5: DEPTH=2 passthrough push+pop while full
        rst_row(4, "t5_rst");
        add(1, 4, 0, 0, 1, 16'h31, 1, 0, 1, 0, 16'h00, 3'd0, "t5_push31");
        add(1, 4, 0, 0, 1, 16'h32, 1, 0, 1, 1, 16'h31, 3'd1, "t5_push32");
        add(1, 4, 0, 0, 1, 16'h77, 1, 0, 0, 1, 16'h31, 3'd2, "t5_full");
        add(1, 4, 0, 0, 1, 16'h77, 1, 1, 1, 1, 16'h31, 3'd2, "t5_pushpop");
        add(1, 4, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h32, 3'd2, "t5_out32");
        add(1, 4, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h77, 3'd1, "t5_out77");
        add(1, 4, 0, 0, 0, 16'h00, 1, 1, 1, 0, 16'h00, 3'd0, "t5_empty");

        // T6: reset mid-stream drops held beats
        rst_row(4, "t6_rst");
        add(1, 4, 0, 0, 1, 16'h41, 1, 0, 1, 0, 16'h00, 3'd0, "t6_push41");
        add(1, 4, 0, 0, 1, 16'h42, 1, 0, 1, 1, 16'h41, 3'd1, "t6_push42");
        add(1, 4, 1, 0, 1, 16'h43, 1, 1, 1, 1, 16'h41, 3'd2, "t6_rst_cycle");
        add(1, 4, 0, 0, 1, 16'h44, 1, 1, 1, 0, 16'h00, 3'd0, "t6_after_rst");
        add(1, 4, 0, 0, 0, 16'h00, 1, 1, 1, 1, 16'h44, 3'd1, "t6_fresh_beat");
        add(1, 4, 0, 0, 0, 16'h00, 1, 1, 1, 0, 16'h00, 3'd0, "t6_empty");

        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].c, vecs[k].vi, vecs[k].d, vecs[k].g, vecs[k].a);
            #1;
            if (vecs[k].chk) begin
                check({vecs[k].tag, ".in_allow"}, int'(ia[vecs[k].inst]), int'(vecs[k].e_ia));
                check({vecs[k].tag, ".validout"}, int'(vo[vecs[k].inst]), int'(vecs[k].e_vo));
                check({vecs[k].tag, ".out_data"}, int'(od[vecs[k].inst]), int'(vecs[k].e_od));
                check({vecs[k].tag, ".count"}, int'(cnt[vecs[k].inst]), int'(vecs[k].e_cnt));
            end
            @(posedge clk);
            #1;
        end

        // Sustained DEPTH=1 streaming: one beat per cycle, occupancy pinned at 1
        drive(1, 0, 0, 16'h0, 0, 0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 8; n++) begin
            drive(0, 0, 1, 16'h100 + 16'(n), 1, 1);
            #1;
            if (n > 0) begin
                check("stream.validout", int'(vo[0]), 1);
                check("stream.out_data", int'(od[0]), 16'h100 + n - 1);
                check("stream.count", int'(cnt[0]), 1);
                check("stream.in_allow", int'(ia[0]), 1);
            end
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 16'h0, 1, 1);
        #1;
        check("stream.last", int'(od[0]), 16'h107);
        @(posedge clk);
        #1;
        check("stream.drained", int'(cnt[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
